nfc_pi_read_sequencer: RTL

- Sequences one NAND DDR data-output burst through the physical input datapath.
- Per command it resets the capture FIFO, drives the RE toggle pattern to the physical output block and opens the capture write window.
- Then monitors the 16-bit stream drain until the last beat and reports completion and error status.
- Sits between the NFC command engine and the physical input/output blocks.

---
 rtl/nfc_pi_pkg.sv | 37 +++
 rtl/nfc_pi_beat_counter.sv | 41 ++++
 rtl/nfc_pi_read_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nfc_pi_pkg.sv
// Shared definitions for the NFC physical-input read sequencer: FSM state
// codes, RE/ALE drive patterns, capture pipeline depth and small helpers.
package nfc_pi_pkg;

    // FSM state codes, kept as plain constants for legacy tool flows
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_BUFRST = 3'd1;
    localparam state_t ST_PRE    = 3'd2;
    localparam state_t ST_BURST  = 3'd3;
    localparam state_t ST_POST   = 3'd4;
    localparam state_t ST_DRAIN  = 3'd5;
    localparam state_t ST_DONE   = 3'd6;

    // Per-quarter RE levels handed to the physical output block
    localparam logic [3:0] RE_IDLE   = 4'b1111;
    localparam logic [3:0] RE_LOW    = 4'b0000;
    localparam logic [3:0] RE_TOGGLE = 4'b0011;

    // Capture qualifier while the write window is open
    localparam logic [3:0] ALE_CAPTURE = 4'b0001;

    // Cycles the physical input datapath needs to push captured data through
    localparam int CAPTURE_LATENCY = 5;

    // Two bytes per beat, odd byte counts round up to a whole beat
    function automatic logic [15:0] beatsFromBytes(input logic [15:0] bytes);
        logic [16:0] sum;
        sum = {1'b0, bytes} + 17'd1;
        return sum[16:1];
    endfunction

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nfc_pi_beat_counter.sv
// Saturating event counter with a synchronous clear and a comparison of the
// value it will hold after this edge against a target. Used both for the
// drained-beat count and for the drain watchdog.
module nfc_pi_beat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] target_i,
    output logic [WIDTH-1:0] count_o,
    output logic             reach_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over increment; the count sticks at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign reach_o = (count_d == target_i);

endmodule

// File: rtl/nfc_pi_read_sequencer.sv
// Sequences one NAND DDR data-output burst: resets the capture FIFO, drives
// the RE preamble/toggle/postamble, opens the capture write window and then
// watches the stream drain until the last beat.
// Optional feature macro: NFC_PI_READ_TIMEOUT_EN adds a drain watchdog that
// aborts a stalled drain with an error, a FIFO reset pulse and completion.
module nfc_pi_read_sequencer
    import nfc_pi_pkg::*;
#(
    parameter int BUF_RST_CYCLES = 4,
    parameter int PRE_CYCLES     = 3,
    parameter int POST_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        iSystemClock,
    input  logic        iModuleReset,
    input  logic        iCmdValid,
    output logic        oCmdReady,
    input  logic [15:0] iCmdByteCount,
    output logic        oPI_BufferReset,
    output logic        oPI_Buff_WE,
    output logic [3:0]  oAddressLatchEnable,
    output logic [3:0]  oPO_ReadEnable,
    input  logic        iPI_DelayReady,
    input  logic        iPI_Buff_Valid,
    input  logic        iPI_Buff_Ready,
    input  logic        iPI_Buff_Last,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic [15:0] oBeatCount
);

    // POST must last long enough for the capture pipeline to flush
    localparam int POST_TOTAL = maxInt(POST_CYCLES, CAPTURE_LATENCY);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] beats_q;
    logic        odd_q;
    logic        bufRst_q, bufRst_d;
    logic [3:0]  re_q, re_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic        handshake;
    logic        countEnable;
    logic        beatReach;
    logic [15:0] beatCount;

    assign oCmdReady   = iModuleReset && (state_q == ST_IDLE) && iPI_DelayReady;
    assign accept      = iCmdValid && oCmdReady;
    assign handshake   = iPI_Buff_Valid && iPI_Buff_Ready;
    assign countEnable = handshake && ((state_q == ST_BURST) ||
                                       (state_q == ST_POST)  ||
                                       (state_q == ST_DRAIN));

    nfc_pi_beat_counter #(.WIDTH(16)) u_beatCounter (
        .clk_i    (iSystemClock),
        .rst_ni   (iModuleReset),
        .clear_i  (accept),
        .inc_i    (countEnable),
        .target_i (beats_q),
        .count_o  (beatCount),
        .reach_o  (beatReach)
    );

`ifdef NFC_PI_READ_TIMEOUT_EN
    logic        timedOut_q, timedOut_d;
    logic [15:0] wdCount;
    logic        wdReach;
    logic        timeoutHit;

    nfc_pi_beat_counter #(.WIDTH(16)) u_watchdog (
        .clk_i    (iSystemClock),
        .rst_ni   (iModuleReset),
        .clear_i  ((state_q != ST_DRAIN) || handshake),
        .inc_i    ((state_q == ST_DRAIN) && !handshake),
        .target_i (16'(TIMEOUT_CYCLES)),
        .count_o  (wdCount),
        .reach_o  (wdReach)
    );

    assign timeoutHit = (state_q == ST_DRAIN) && !handshake && wdReach;
`endif

    // Phase sequencing: each timed phase counts its own cycles in cnt
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef NFC_PI_READ_TIMEOUT_EN
        timedOut_d = timedOut_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUFRST;
                    cnt_d   = '0;
`ifdef NFC_PI_READ_TIMEOUT_EN
                    timedOut_d = 1'b0;
`endif
                end
            end
            ST_BUFRST: begin
                if (cnt_q == 16'(BUF_RST_CYCLES - 1)) begin
                    cnt_d = '0;
`ifdef NFC_PI_READ_TIMEOUT_EN
                    state_d = timedOut_q ? ST_DONE : ST_PRE;
`else
                    state_d = ST_PRE;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_PRE: begin
                if (cnt_q == 16'(PRE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (beats_q == '0) ? ST_POST : ST_BURST;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_BURST: begin
                if (cnt_q == beats_q - 16'd1) begin
                    cnt_d   = '0;
                    state_d = ST_POST;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_POST: begin
                if (cnt_q == 16'(POST_TOTAL - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (handshake && iPI_Buff_Last) begin
                    state_d = ST_DONE;
                end
`ifdef NFC_PI_READ_TIMEOUT_EN
                else if (timeoutHit) begin
                    state_d    = ST_BUFRST;
                    cnt_d      = '0;
                    timedOut_d = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output drive decoded from the upcoming phase so the pins line up with the state
    always_comb begin
        bufRst_d = (state_d == ST_BUFRST);
        done_d   = (state_d == ST_DONE);
        we_d     = (state_d == ST_BURST) ||
                   ((state_d == ST_POST) && (cnt_d < 16'(CAPTURE_LATENCY)));
        re_d     = RE_IDLE;
        if (state_d == ST_PRE) begin
            re_d = RE_LOW;
        end else if (state_d == ST_BURST) begin
            re_d = RE_TOGGLE;
        end
    end

    // Sticky error: cleared by a new command, judged when the burst completes
    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end
`ifdef NFC_PI_READ_TIMEOUT_EN
        if (timeoutHit) begin
            err_d = 1'b1;
        end
`endif
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            err_d = err_q | ~beatReach | odd_q;
        end
    end

    // State, command latch and registered outputs; reset holds the FIFO in reset
    always_ff @(posedge iSystemClock or negedge iModuleReset) begin
        if (!iModuleReset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            beats_q  <= '0;
            odd_q    <= 1'b0;
            bufRst_q <= 1'b1;
            re_q     <= RE_IDLE;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bufRst_q <= bufRst_d;
            re_q     <= re_d;
            we_q     <= we_d;
            done_q   <= done_d;
            err_q    <= err_d;
            if (accept) begin
                beats_q <= beatsFromBytes(iCmdByteCount);
                odd_q   <= iCmdByteCount[0];
            end
        end
    end

`ifdef NFC_PI_READ_TIMEOUT_EN
    // Remembers that the current FIFO reset hold is the timeout abort path
    always_ff @(posedge iSystemClock or negedge iModuleReset) begin
        if (!iModuleReset) begin
            timedOut_q <= 1'b0;
        end else begin
            timedOut_q <= timedOut_d;
        end
    end
`endif

    assign oPI_BufferReset     = bufRst_q;
    assign oPO_ReadEnable      = re_q;
    assign oPI_Buff_WE         = we_q;
    assign oAddressLatchEnable = we_q ? ALE_CAPTURE : 4'b0000;
    assign oBusy               = (state_q != ST_IDLE);
    assign oDone               = done_q;
    assign oError              = err_q;
    assign oBeatCount          = beatCount;

endmodule
